spec_commit_store_buffer: RTL

Parametrised two-stage store buffer that sits between the store unit's address-translation stage and the D$ write port.
- Stores enter a speculative FIFO and are discarded on flush.
- On commit they move to a commit FIFO that drains to memory through a req/gnt handshake.
- New in this generation: configurable data width and both queue depths, optional write-merging of same-word stores into the commit tail, and occupancy outputs.

---
 rtl/spec_commit_store_buffer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/spec_commit_store_buffer.sv
// rtl/spec_commit_store_buffer.sv - two-stage speculative/commit store buffer in front of the D$ write port
//
// Stores are pushed into a speculative FIFO (valid_i/ready_o). commit_i moves the
// oldest speculative store into the commit FIFO. It is either appended, or merged
// into the commit tail when it writes the same word. The commit FIFO drains to
// memory through mem_req_o/mem_gnt_i. flush_i discards all speculative entries.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   flush_i                       drop all speculative stores
//   valid_i/ready_o               incoming store handshake (paddr_i, data_i, be_i)
//   commit_i/commit_ready_o       commit oldest speculative store
//   page_offset_i                 load page offset for the hazard check
//   page_offset_matches_o         a pending or incoming store hits the same word
//   no_st_pending_o               both queues empty
//   spec_count_o, commit_count_o  queue occupancies
//   mem_req_o/mem_gnt_i           write request handshake (mem_addr_o, mem_data_o, mem_be_o)
module spec_commit_store_buffer #(
    parameter int SPEC_DEPTH   = 4,
    parameter int COMMIT_DEPTH = 8,
    parameter int ADDR_WIDTH   = 56,
    parameter int DATA_WIDTH   = 64,
    parameter int ENABLE_MERGE = 1,
    localparam int BE_WIDTH    = DATA_WIDTH / 8,
    localparam int OFS         = $clog2(BE_WIDTH),
    localparam int SAW         = $clog2(SPEC_DEPTH),
    localparam int CAW         = $clog2(COMMIT_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic                  commit_i,
    output logic                  commit_ready_o,
    input  logic [11:0]           page_offset_i,
    output logic                  page_offset_matches_o,
    output logic                  no_st_pending_o,
    output logic [SAW:0]          spec_count_o,
    output logic [CAW:0]          commit_count_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [BE_WIDTH-1:0]   mem_be_o
);

    localparam logic [SAW:0]   S_FULL = (SAW + 1)'(SPEC_DEPTH);
    localparam logic [CAW:0]   C_FULL = (CAW + 1)'(COMMIT_DEPTH);
    localparam logic [SAW:0]   S_ONE  = (SAW + 1)'(1);
    localparam logic [CAW:0]   C_ONE  = (CAW + 1)'(1);
    localparam logic [CAW:0]   C_TWO  = (CAW + 1)'(2);
    localparam logic [SAW-1:0] SP_ONE = SAW'(1);
    localparam logic [CAW-1:0] CP_ONE = CAW'(1);

    // Only the word address is kept: byte position within a word is carried by be.
    logic [ADDR_WIDTH-1:OFS] s_addr_q [SPEC_DEPTH];
    logic [ADDR_WIDTH-1:OFS] s_addr_d [SPEC_DEPTH];
    logic [DATA_WIDTH-1:0]   s_data_q [SPEC_DEPTH];
    logic [DATA_WIDTH-1:0]   s_data_d [SPEC_DEPTH];
    logic [BE_WIDTH-1:0]     s_be_q   [SPEC_DEPTH];
    logic [BE_WIDTH-1:0]     s_be_d   [SPEC_DEPTH];
    logic [SAW-1:0]          s_head_q, s_head_d, s_tail_q, s_tail_d;
    logic [SAW:0]            s_cnt_q, s_cnt_d;

    logic [ADDR_WIDTH-1:OFS] c_addr_q [COMMIT_DEPTH];
    logic [ADDR_WIDTH-1:OFS] c_addr_d [COMMIT_DEPTH];
    logic [DATA_WIDTH-1:0]   c_data_q [COMMIT_DEPTH];
    logic [DATA_WIDTH-1:0]   c_data_d [COMMIT_DEPTH];
    logic [BE_WIDTH-1:0]     c_be_q   [COMMIT_DEPTH];
    logic [BE_WIDTH-1:0]     c_be_d   [COMMIT_DEPTH];
    logic [CAW-1:0]          c_head_q, c_head_d, c_tail_q, c_tail_d;
    logic [CAW:0]            c_cnt_q, c_cnt_d;

    logic [CAW-1:0] c_last;
    logic           merge_ok, push, commit_fire, pop;
    logic           unused_low_bits;

    assign unused_low_bits = ^{paddr_i[OFS-1:0], page_offset_i[OFS-1:0]};

    assign c_last   = c_tail_q - CP_ONE;
    // The head is being presented to memory, so it is never a merge target.
    assign merge_ok = (ENABLE_MERGE != 0) && (c_cnt_q >= C_TWO) && (s_cnt_q != '0)
                      && (c_addr_q[c_last] == s_addr_q[s_head_q]);

    assign ready_o         = (s_cnt_q < S_FULL);
    assign commit_ready_o  = (s_cnt_q != '0) && ((c_cnt_q != C_FULL) || merge_ok);
    assign mem_req_o       = (c_cnt_q != '0);
    assign no_st_pending_o = (s_cnt_q == '0) && (c_cnt_q == '0);
    assign spec_count_o    = s_cnt_q;
    assign commit_count_o  = c_cnt_q;
    assign mem_addr_o      = mem_req_o ? {c_addr_q[c_head_q], {OFS{1'b0}}} : '0;
    assign mem_data_o      = mem_req_o ? c_data_q[c_head_q] : '0;
    assign mem_be_o        = mem_req_o ? c_be_q[c_head_q] : '0;

    assign push        = valid_i && ready_o && !flush_i;
    assign commit_fire = commit_i && commit_ready_o;
    assign pop         = mem_req_o && mem_gnt_i;

    // Entry i is live when its distance from the head is below the occupancy.
    always_comb begin
        page_offset_matches_o = valid_i && (paddr_i[11:OFS] == page_offset_i[11:OFS]);
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            if ({1'b0, SAW'(i) - s_head_q} < s_cnt_q
                && s_addr_q[i][11:OFS] == page_offset_i[11:OFS])
                page_offset_matches_o = 1'b1;
        end
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            if ({1'b0, CAW'(i) - c_head_q} < c_cnt_q
                && c_addr_q[i][11:OFS] == page_offset_i[11:OFS])
                page_offset_matches_o = 1'b1;
        end
    end

    always_comb begin
        s_addr_d = s_addr_q;
        s_data_d = s_data_q;
        s_be_d   = s_be_q;
        s_head_d = s_head_q;
        s_tail_d = s_tail_q;
        s_cnt_d  = s_cnt_q;
        c_addr_d = c_addr_q;
        c_data_d = c_data_q;
        c_be_d   = c_be_q;
        c_head_d = c_head_q;
        c_tail_d = c_tail_q;
        c_cnt_d  = c_cnt_q;

        if (pop) begin
            c_head_d = c_head_q + CP_ONE;
            c_cnt_d  = c_cnt_d - C_ONE;
        end

        if (commit_fire) begin
            s_head_d = s_head_q + SP_ONE;
            s_cnt_d  = s_cnt_d - S_ONE;
            if (merge_ok) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (s_be_q[s_head_q][b])
                        c_data_d[c_last][8*b +: 8] = s_data_q[s_head_q][8*b +: 8];
                end
                c_be_d[c_last] = c_be_q[c_last] | s_be_q[s_head_q];
            end else begin
                c_addr_d[c_tail_q] = s_addr_q[s_head_q];
                c_data_d[c_tail_q] = s_data_q[s_head_q];
                c_be_d[c_tail_q]   = s_be_q[s_head_q];
                c_tail_d           = c_tail_q + CP_ONE;
                c_cnt_d            = c_cnt_d + C_ONE;
            end
        end

        if (flush_i) begin
            s_head_d = '0;
            s_tail_d = '0;
            s_cnt_d  = '0;
        end else if (push) begin
            s_addr_d[s_tail_q] = paddr_i[ADDR_WIDTH-1:OFS];
            s_data_d[s_tail_q] = data_i;
            s_be_d[s_tail_q]   = be_i;
            s_tail_d           = s_tail_q + SP_ONE;
            s_cnt_d            = s_cnt_d + S_ONE;
        end
    end

    // Payload arrays need no reset: outputs are gated by the occupancy counts.
    always_ff @(posedge clk_i) begin
        s_addr_q <= s_addr_d;
        s_data_q <= s_data_d;
        s_be_q   <= s_be_d;
        c_addr_q <= c_addr_d;
        c_data_q <= c_data_d;
        c_be_q   <= c_be_d;
        if (rst_i) begin
            s_head_q <= '0;
            s_tail_q <= '0;
            s_cnt_q  <= '0;
            c_head_q <= '0;
            c_tail_q <= '0;
            c_cnt_q  <= '0;
        end else begin
            s_head_q <= s_head_d;
            s_tail_q <= s_tail_d;
            s_cnt_q  <= s_cnt_d;
            c_head_q <= c_head_d;
            c_tail_q <= c_tail_d;
            c_cnt_q  <= c_cnt_d;
        end
    end

endmodule
